// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock.
// Returns quotient, remainder and a Z/N/V status word matching the ALU flags.
// Optional feature macro: SEQ_DIVIDER_SIGNED_EN (two's complement operands).
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   start      request strobe, accepted only in IDLE
//   Ain, Bin   dividend / divisor, sampled on accepted start
//   busy       high while an operation is in progress
//   done       one-cycle pulse when results update
//   quotient   registered quotient
//   remainder  registered remainder
//   status     {V, N, Z}: V = divide-by-zero or signed overflow,
//              N = quotient MSB, Z = quotient is zero
module seq_divider #(
  parameter int unsigned width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [width-1:0] Ain,
  input  logic [width-1:0] Bin,
  output logic             busy,
  output logic             done,
  output logic [width-1:0] quotient,
  output logic [width-1:0] remainder,
  output logic [2:0]       status
);

  localparam int unsigned CW = $clog2(width);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [width-1:0] rem_q;   // partial remainder
  logic [width-1:0] quo_q;   // dividend shifts out the top, quotient shifts in
  logic [width-1:0] div_q;   // divisor (magnitude)
  logic             dz_q;    // divide-by-zero flag

  logic [width-1:0] a_mag, b_mag;
  logic [width-1:0] q_fin, r_fin;
  logic             v_fin;
  logic [width:0]   shifted, diff;
  logic             no_borrow;

  // Next partial remainder candidate with the next dividend bit shifted in.
  assign shifted = {rem_q, quo_q[width-1]};

  // width+1-bit trial subtraction; carry-out set means no borrow.
  assign {no_borrow, diff} = {1'b0, shifted} + {1'b0, ~{1'b0, div_q}} + (width+2)'(1);

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q, neg_r, ovf_q, ovf_in;

  // Magnitudes taken at start; the core iterates on unsigned values.
  always_comb begin
    a_mag  = Ain[width-1] ? (~Ain + width'(1)) : Ain;
    b_mag  = Bin[width-1] ? (~Bin + width'(1)) : Bin;
    ovf_in = (Ain == {1'b1, {(width-1){1'b0}}}) && (Bin == '1);
  end

  // Re-apply signs; most-negative / -1 naturally yields most-negative.
  always_comb begin
    q_fin = neg_q ? (~quo_q + width'(1)) : quo_q;
    r_fin = neg_r ? (~rem_q + width'(1)) : rem_q;
    v_fin = dz_q | ovf_q;
  end
`else
  always_comb begin
    a_mag = Ain;
    b_mag = Bin;
    q_fin = quo_q;
    r_fin = rem_q;
    v_fin = dz_q;
  end
`endif

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      status    <= 3'b000;
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      dz_q      <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            div_q <= b_mag;
            dz_q  <= (Bin == '0);
            cnt   <= CW'(width - 1);
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q <= (Bin != '0) && (Ain[width-1] ^ Bin[width-1]);
            neg_r <= (Bin != '0) && Ain[width-1];
            ovf_q <= ovf_in;
`endif
            if (Bin == '0) begin
              // Divide-by-zero result is formed directly; no iteration.
              quo_q <= '1;
              rem_q <= Ain;
              state <= S_DONE;
            end else begin
              quo_q <= a_mag;
              rem_q <= '0;
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          // Keep the difference on no-borrow, otherwise restore.
          rem_q <= width'(no_borrow ? diff : shifted);
          quo_q <= {quo_q[width-2:0], no_borrow};
          if (cnt == '0) begin
            state <= S_DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_DONE: begin
          quotient  <= q_fin;
          remainder <= r_fin;
          status    <= {v_fin, q_fin[width-1], (q_fin == '0)};
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider at width 8: the driver pushes expected
// results with their due cycle, a monitor pops and compares on each done.
module tb_seq_divider;

  localparam int unsigned W = 8;
  localparam int NV = 9;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [W-1:0] ain, bin;
  logic         busy, done;
  logic [W-1:0] quotient, remainder;
  logic [2:0]   status;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic [2:0]   s;
    int           due;
    int           tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  seq_divider #(.width(W)) dut (
    .clk(clk), .reset(reset), .start(start), .Ain(ain), .Bin(bin),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .status(status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Directed vectors: dividend, divisor, quotient, remainder, status, latency.
  logic [W-1:0] va [NV] = '{8'd100, 8'd55, 8'd200, 8'd255, 8'd3, 8'd0, 8'hF9, 8'h80, 8'h07};
  logic [W-1:0] vb [NV] = '{8'd7,   8'd0,  8'd10,  8'd1,   8'd9, 8'd0, 8'h02, 8'hFF, 8'hFE};
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic [W-1:0] vq [NV] = '{8'd14,  8'hFF, 8'hFB,  8'hFF,  8'd0, 8'hFF, 8'hFD, 8'h80, 8'hFD};
  logic [W-1:0] vr [NV] = '{8'd2,   8'd55, 8'hFA,  8'd0,   8'd3, 8'd0,  8'hFF, 8'h00, 8'h01};
  logic [2:0]   vs [NV] = '{3'b000, 3'b110, 3'b010, 3'b010, 3'b001, 3'b110, 3'b010, 3'b110, 3'b010};
`else
  logic [W-1:0] vq [NV] = '{8'd14,  8'hFF, 8'd20,  8'hFF,  8'd0, 8'hFF, 8'h7C, 8'h00, 8'h00};
  logic [W-1:0] vr [NV] = '{8'd2,   8'd55, 8'd0,   8'd0,   8'd3, 8'd0,  8'h01, 8'h80, 8'h07};
  logic [2:0]   vs [NV] = '{3'b000, 3'b110, 3'b000, 3'b010, 3'b001, 3'b110, 3'b000, 3'b001, 3'b001};
`endif
  int           vl [NV] = '{9, 1, 9, 9, 9, 1, 9, 9, 9};

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      checks++;
      if (busy !== 1'b0) begin
        fails++;
        $display("FAIL busy_with_done: busy=%b required 0", busy);
      end
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL spurious_done cycle %0d: done=1 required 0", cyc);
      end else begin
        e = sb.pop_front();
        if (quotient !== e.q || remainder !== e.r || status !== e.s) begin
          fails++;
          $display("FAIL result tag=%0d: got q=%h r=%h s=%b required q=%h r=%h s=%b",
                   e.tag, quotient, remainder, status, e.q, e.r, e.s);
        end
        checks++;
        if (cyc != e.due) begin
          fails++;
          $display("FAIL latency tag=%0d: done at cycle %0d required %0d", e.tag, cyc, e.due);
        end
      end
    end
  end

  // Drive one start (called at a negedge); optionally register the expectation.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] q, input logic [W-1:0] r,
                       input logic [2:0] s, input int lat, input bit expect_it,
                       input int tag);
    start = 1'b1;
    ain   = a;
    bin   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_after_start tag=%0d: busy=%b required 1", tag, busy);
    end
    if (expect_it) sb.push_back('{q, r, s, cyc + lat, tag});
  endtask

  // Wait (bounded) for a done pulse; returns at the negedge where done is seen.
  task automatic wait_done(input int tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      fails++;
      $display("FAIL timeout tag=%0d: done=0 required 1 within 40 cycles", tag);
      sb.delete();
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    ain   = '0;
    bin   = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, quotient, remainder, status} !== '0) begin
      fails++;
      $display("FAIL reset_state: busy=%b done=%b q=%h r=%h s=%b required all 0",
               busy, done, quotient, remainder, status);
    end
    reset = 1'b0;
    @(negedge clk);

    // Back-to-back directed vectors: each start issued right after done.
    for (int i = 0; i < NV; i++) begin
      issue(va[i], vb[i], vq[i], vr[i], vs[i], vl[i], 1'b1, i);
      wait_done(i);
    end

    // start pulsed mid-RUN with new operands must be ignored.
    issue(8'd100, 8'd7, 8'd14, 8'd2, 3'b000, 9, 1'b1, 100);
    repeat (3) @(negedge clk);
    start = 1'b1;
    ain   = 8'd50;
    bin   = 8'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(100);
    repeat (3) @(negedge clk);

    // Reset mid-RUN aborts with no done; outputs clear.
    issue(8'd100, 8'd7, 8'd0, 8'd0, 3'b000, 9, 1'b0, 200);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, done, quotient, remainder, status} !== '0) begin
      fails++;
      $display("FAIL reset_abort: busy=%b done=%b q=%h r=%h s=%b required all 0",
               busy, done, quotient, remainder, status);
    end
    repeat (15) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_abort: busy=%b required 0", busy);
    end
    issue(8'd20, 8'd5, 8'd4, 8'd0, 3'b000, 9, 1'b1, 201);
    wait_done(201);

    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL leftover_expectations: %0d pending required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
